// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between an instruction fetch port and a
// load/store data port. Data wins by default; a waiting fetch wins after STARVE_LIMIT data grants.
//
// state   | meaning
// IDLE    | arbitrate pending requests, no memory command driven
// GRANT_I | fetch read held on memory port until accepted
// GRANT_D | load or store held on memory port until accepted
// RESP_I  | read data returned to the fetch port
// RESP_D  | read data returned to the data port
module mem_port_arbiter #(
    parameter int WORD_SIZE    = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 Clock,
    input  logic                 Reset,

    input  logic                 InstrReq,
    input  logic [WORD_SIZE-1:0] InstrAddr,
    output logic [WORD_SIZE-1:0] InstrIn,
    output logic                 InstrWaitreq,

    input  logic                 ReadData,
    input  logic                 WriteData,
    input  logic [WORD_SIZE-1:0] DataAddr,
    input  logic [WORD_SIZE-1:0] DataOut,
    output logic [WORD_SIZE-1:0] DataIn,
    output logic                 DataWaitreq,

    output logic [WORD_SIZE-1:0] MemAddr,
    output logic [WORD_SIZE-1:0] MemWdata,
    output logic                 MemRead,
    output logic                 MemWrite,
    input  logic [WORD_SIZE-1:0] MemRdata,
    input  logic                 MemWaitreq,

    output logic                 ProtoErr
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] GRANT_I = 3'd1;
    localparam logic [2:0] GRANT_D = 3'd2;
    localparam logic [2:0] RESP_I  = 3'd3;
    localparam logic [2:0] RESP_D  = 3'd4;

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [2:0]    state;
    logic [2:0]    state_next;
    logic [CW-1:0] starve_cnt;
    logic          data_req;
    logic          pick_instr;
    logic          pick_data;
    logic          starved;
    logic          write_accept;

    assign data_req     = ReadData | WriteData;
    assign starved      = (starve_cnt == LIMIT);
    assign pick_instr   = InstrReq & (~data_req | starved);
    assign pick_data    = data_req & ~pick_instr;
    assign write_accept = (state == GRANT_D) & MemWrite & ~MemWaitreq;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (pick_instr) begin
                    state_next = GRANT_I;
                end else if (pick_data) begin
                    state_next = GRANT_D;
                end
            end
            GRANT_I: begin
                if (!MemWaitreq) begin
                    state_next = RESP_I;
                end
            end
            GRANT_D: begin
                if (!MemWaitreq) begin
                    state_next = MemWrite ? IDLE : RESP_D;
                end
            end
            RESP_I:  state_next = IDLE;
            RESP_D:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            ProtoErr   <= 1'b0;
            MemAddr    <= '0;
            MemWdata   <= '0;
            MemRead    <= 1'b0;
            MemWrite   <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (pick_instr || !InstrReq) begin
                        starve_cnt <= '0;
                    end else if (pick_data && !starved) begin
                        starve_cnt <= starve_cnt + CW'(1);
                    end
                    if (ReadData && WriteData) begin
                        ProtoErr <= 1'b1;
                    end
                    if (pick_instr) begin
                        MemAddr  <= InstrAddr;
                        MemWdata <= '0;
                        MemRead  <= 1'b1;
                        MemWrite <= 1'b0;
                    end else if (pick_data) begin
                        // a conflicting load/store pair is served as a load
                        MemAddr  <= DataAddr;
                        MemWdata <= ReadData ? '0 : DataOut;
                        MemRead  <= ReadData;
                        MemWrite <= ~ReadData;
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (!MemWaitreq) begin
                        MemAddr  <= '0;
                        MemWdata <= '0;
                        MemRead  <= 1'b0;
                        MemWrite <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // A requester that dropped its request still sees the response bus, but nobody consumes it.
    always_comb begin
        InstrIn      = (state == RESP_I) ? MemRdata : '0;
        DataIn       = (state == RESP_D) ? MemRdata : '0;
        InstrWaitreq = InstrReq & (state != RESP_I);
        DataWaitreq  = data_req & ~((state == RESP_D) | write_accept);
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: WORD_SIZE, 16, data/address width; STARVE_LIMIT, 4, consecutive data grants allowed while an instruction request waits.
REQ-002 Clock SHALL be: Clock  in  1  rising-edge clock.
REQ-003 Reset SHALL be: Reset  in  1  synchronous, active-high.
REQ-004 Instruction port SHALL be: InstrReq in 1 fetch request; InstrAddr in WORD_SIZE fetch address; InstrIn out WORD_SIZE fetched word; InstrWaitreq out 1 fetch not yet complete.
REQ-005 Data port SHALL be: ReadData in 1 load request; WriteData in 1 store request; DataAddr in WORD_SIZE address; DataOut in WORD_SIZE store data; DataIn out WORD_SIZE load data; DataWaitreq out 1 access not yet complete.
REQ-006 Memory port SHALL be: MemAddr out WORD_SIZE; MemWdata out WORD_SIZE; MemRead out 1; MemWrite out 1; MemRdata in WORD_SIZE, valid exactly one cycle after read acceptance; MemWaitreq in 1, command not accepted this cycle.
REQ-007 ProtoErr SHALL be: out 1, sticky flag set by simultaneous ReadData and WriteData.

Function
REQ-008 The block SHALL share one single-ported memory between the fetch and data ports using states IDLE, GRANT_I, GRANT_D, RESP_I, RESP_D.
REQ-009 In IDLE it SHALL arbitrate among pending requests, issue no memory command, and move to GRANT_I or GRANT_D next cycle; with no request it stays in IDLE.
REQ-010 Data requests SHALL win over InstrReq, except that instruction wins once the starvation counter equals STARVE_LIMIT.
REQ-011 The starvation counter SHALL increment on each data grant while InstrReq is high, SHALL clear on instruction grant or when InstrReq is low in IDLE, and SHALL saturate at STARVE_LIMIT.
REQ-012 In GRANT states it SHALL drive MemAddr, MemWdata, MemRead/MemWrite from the granted port, registered at grant, and hold them stable while MemWaitreq=1.
REQ-013 Read accepted (MemWaitreq=0): next state SHALL be RESP_I/RESP_D; write accepted: next state SHALL be IDLE, with DataWaitreq=0 in the accepting cycle.
REQ-014 In RESP_x it SHALL pass MemRdata combinationally to InstrIn/DataIn, drive that port's waitreq 0 for exactly that cycle, then go to IDLE.
REQ-015 Each waitreq SHALL be 1 whenever its port requests and is not completing this cycle, and 0 when the port is idle.
REQ-016 Minimum latency SHALL be 3 cycles for a read (request to waitreq low) and 2 cycles for a write.
REQ-017 A requester dropping its request after grant SHALL NOT withdraw the memory command; the transaction completes and its response is discarded.
REQ-018 ReadData and WriteData both high at arbitration SHALL be served as a read and SHALL set ProtoErr.
REQ-019 DataIn/InstrIn SHALL be 0 outside RESP_D/RESP_I respectively.

Reset
REQ-020 Reset SHALL force IDLE, clear counter and ProtoErr, and deassert MemRead/MemWrite in the following cycle, including mid-transaction; any in-flight response is discarded.
REQ-021 After reset, all outputs SHALL be 0, except that waitreqs follow REQ-015.

Verification
REQ-022 Lone fetch at 0x0010, MemRdata=0xABCD, MemWaitreq=0 -> MemRead with MemAddr=0x0010 in cycle 1, InstrIn=0xABCD, InstrWaitreq=0 in cycle 2.
REQ-023 Store 0x1234 to 0x0040 with MemWaitreq high 3 cycles -> MemWrite/MemAddr/MemWdata stable 4 cycles, DataWaitreq=0 only in the accept cycle.
REQ-024 InstrReq and continuous loads held high -> exactly 4 data grants, then 1 instruction grant, then the pattern repeats.
REQ-025 Simultaneous InstrReq and ReadData in IDLE with counter 0 -> data granted first, instruction next.
REQ-026 Reset asserted in RESP_D -> next cycle IDLE, MemRead=0, DataIn=0, ProtoErr=0.
REQ-027 ReadData=WriteData=1 -> read issued, ProtoErr=1 held until Reset.
